// File: rtl/gmii_frame_tx.sv
// GMII frame transmitter: drains a show-ahead packet FIFO into preamble/SFD/payload on GMII TX.
// Define GMII_TX_FCS_EN to append a CRC-32 FCS; by default the payload is sent as-is.
module gmii_frame_tx (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_d,
    input  logic       fifo_er,
    input  logic       fifo_frame_end,
    output logic       fifo_en,
    output logic       tx_en,
    output logic [7:0] txd,
    output logic       tx_er,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_SFD      = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_DROP     = 3'd5;
    localparam logic [2:0] ST_IFG      = 3'd6;
`ifdef GMII_TX_FCS_EN
    localparam logic [2:0] ST_FCS      = 3'd4;
    localparam logic [3:0] FCS_LAST    = 4'd3;
`endif

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [3:0] PREAMBLE_LAST = 4'd6;
    // The first IFG cycle still shows the frame tail, so 12 IFG cycles plus
    // the IDLE cycle give exactly 12 low cycles of tx_en between frames.
    localparam logic [3:0] IFG_LAST      = 4'd11;

    logic [2:0] state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       tx_en_next, tx_er_next, frame_done_next, underrun_next;
    logic [7:0] txd_next;

    always_comb begin
        fifo_en = 1'b0;
        case (state_reg)
            ST_SFD, ST_DATA, ST_DROP: fifo_en = !fifo_empty;
            default:                  fifo_en = 1'b0;
        endcase
    end

`ifdef GMII_TX_FCS_EN
    logic [31:0] crc_reg, crc_next;
    logic [31:0] crc_chain [0:8];
    logic [31:0] fcs_val;
    logic [7:0]  fcs_byte;

    // Reflected CRC-32, one bit per stage, LSB of the byte first.
    assign crc_chain[0] = crc_reg ^ {24'h000000, fifo_d};
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
            assign crc_chain[gi+1] = crc_chain[gi][0] ? ((crc_chain[gi] >> 1) ^ 32'hEDB88320)
                                                      : (crc_chain[gi] >> 1);
        end
    endgenerate

    always_comb begin
        crc_next = crc_reg;
        if (state_reg == ST_PREAMBLE)
            crc_next = 32'hFFFFFFFF;
        else if (fifo_en && (state_reg == ST_SFD || state_reg == ST_DATA))
            crc_next = crc_chain[8];
    end

    assign fcs_val  = ~crc_reg;
    assign fcs_byte = fcs_val[{cnt_reg[1:0], 3'b000} +: 8];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            crc_reg <= 32'hFFFFFFFF;
        else
            crc_reg <= crc_next;
    end
`endif

    // Outputs are registered with the value for the state being entered, so a
    // word popped in one cycle is on the wire in the next.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        tx_en_next      = 1'b0;
        txd_next        = 8'h00;
        tx_er_next      = 1'b0;
        frame_done_next = 1'b0;
        underrun_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_PREAMBLE;
                    cnt_next   = 4'd0;
                    tx_en_next = 1'b1;
                    txd_next   = PREAMBLE_BYTE;
                end
            end
            ST_PREAMBLE: begin
                tx_en_next = 1'b1;
                if (cnt_reg == PREAMBLE_LAST) begin
                    state_next = ST_SFD;
                    txd_next   = SFD_BYTE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                    txd_next = PREAMBLE_BYTE;
                end
            end
            ST_SFD, ST_DATA: begin
                tx_en_next = 1'b1;
                if (fifo_empty) begin
                    tx_er_next    = 1'b1;
                    underrun_next = 1'b1;
                    state_next    = ST_DROP;
                end else begin
                    txd_next   = fifo_d;
                    tx_er_next = fifo_er;
                    if (fifo_frame_end) begin
                        cnt_next = 4'd0;
`ifdef GMII_TX_FCS_EN
                        state_next = ST_FCS;
`else
                        state_next      = ST_IFG;
                        frame_done_next = 1'b1;
`endif
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
`ifdef GMII_TX_FCS_EN
            ST_FCS: begin
                tx_en_next = 1'b1;
                txd_next   = fcs_byte;
                if (cnt_reg == FCS_LAST) begin
                    state_next      = ST_IFG;
                    cnt_next        = 4'd0;
                    frame_done_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
`endif
            ST_DROP: begin
                if (!fifo_empty && fifo_frame_end) begin
                    state_next = ST_IFG;
                    cnt_next   = 4'd0;
                end
            end
            ST_IFG: begin
                if (cnt_reg == IFG_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 4'd0;
            tx_en      <= 1'b0;
            txd        <= 8'h00;
            tx_er      <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            tx_en      <= tx_en_next;
            txd        <= txd_next;
            tx_er      <= tx_er_next;
            frame_done <= frame_done_next;
            underrun   <= underrun_next;
        end
    end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Scoreboard bench for gmii_frame_tx: stimulus queues expected wire bytes and events,
// a monitor pops and compares them whenever tx_en, frame_done or underrun is seen.
`timescale 1ns/1ps
module tb_gmii_frame_tx;

    logic       clock;
    logic       reset_n;
    logic       fifo_empty;
    logic [7:0] fifo_d;
    logic       fifo_er;
    logic       fifo_frame_end;
    logic       fifo_en;
    logic       tx_en;
    logic [7:0] txd;
    logic       tx_er;
    logic       frame_done;
    logic       underrun;

    gmii_frame_tx dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .fifo_empty     (fifo_empty),
        .fifo_d         (fifo_d),
        .fifo_er        (fifo_er),
        .fifo_frame_end (fifo_frame_end),
        .fifo_en        (fifo_en),
        .tx_en          (tx_en),
        .txd            (txd),
        .tx_er          (tx_er),
        .frame_done     (frame_done),
        .underrun       (underrun)
    );

    typedef struct {
        logic [7:0] d;
        logic       er;
        int         gap;   // -1 don't care, -2 at least 12, else exact idle count
    } exp_t;

    localparam int EV_DONE     = 1;
    localparam int EV_UNDERRUN = 2;

    exp_t       exp_q[$];
    int         ev_q[$];
    logic [9:0] fq[$];          // {frame_end, er, data}
    logic [7:0] st_d[$];
    logic       st_er[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         idle_cnt = 0;

    initial begin
        clock = 1'b0;
        forever #4 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [31:0] crc_in, input logic [7:0] b);
        logic [31:0] c;
        c = crc_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic er, input int gap);
        exp_t e;
        e.d = d; e.er = er; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_preamble(input int gap);
        push_exp(8'h55, 1'b0, gap);
        for (int k = 0; k < 6; k++) push_exp(8'h55, 1'b0, -1);
        push_exp(8'hD5, 1'b0, -1);
    endtask

    task automatic st_clear();
        st_d.delete();
        st_er.delete();
    endtask

    task automatic st_add(input logic [7:0] d, input logic er);
        st_d.push_back(d);
        st_er.push_back(er);
    endtask

    // Queue the staged frame into the FIFO and its expected wire image into the scoreboard.
    task automatic load_frame(input int gap, input bit use_hand, input logic [31:0] hand_fcs,
                              input string name);
        logic [31:0] crc;
        logic [31:0] fcs;
        int          n;
        n   = st_d.size();
        crc = 32'hFFFFFFFF;
        push_preamble(gap);
        for (int i = 0; i < n; i++) begin
            fq.push_back({(i == n - 1), st_er[i], st_d[i]});
            push_exp(st_d[i], st_er[i], -1);
            crc = crc_model(crc, st_d[i]);
        end
        fcs = use_hand ? hand_fcs : ~crc;
`ifdef GMII_TX_FCS_EN
        for (int k = 0; k < 4; k++) push_exp(fcs[8*k +: 8], 1'b0, -1);
`endif
        ev_q.push_back(EV_DONE);
        $display("frame %s: %0d payload bytes queued, fcs %08h", name, n, fcs);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ev_q.size() != 0 || fq.size() != 0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 3000), 32'd1);
        repeat (20) @(negedge clock);
    endtask

    // Show-ahead FIFO model: pop decided at negedge, applied at the next posedge.
    initial begin : fifo_model
        bit pop;
        fifo_empty = 1'b1; fifo_d = 8'h00; fifo_er = 1'b0; fifo_frame_end = 1'b0;
        forever begin
            @(negedge clock);
            pop = fifo_en && !fifo_empty;
            @(posedge clock);
            if (pop && fq.size() > 0) fq.delete(0);
            #1;
            if (fq.size() > 0) begin
                fifo_empty = 1'b0;
                {fifo_frame_end, fifo_er, fifo_d} = fq[0];
            end else begin
                fifo_empty = 1'b1;
                {fifo_frame_end, fifo_er, fifo_d} = 10'h000;
            end
        end
    end

    initial begin : monitor
        exp_t it;
        int   ev;
        forever begin
            @(negedge clock);
            if (tx_en) begin
                check("exp_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    it = exp_q.pop_front();
                    check("txd", {24'h0, txd}, {24'h0, it.d});
                    check("tx_er", {31'h0, tx_er}, {31'h0, it.er});
                    if (it.gap == -2)
                        check("gap_min12", 32'(idle_cnt >= 12), 32'd1);
                    else if (it.gap >= 0)
                        check("gap_exact", 32'(idle_cnt), 32'(it.gap));
                end
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
            if (frame_done) begin
                check("done_expected", 32'(ev_q.size() != 0), 32'd1);
                if (ev_q.size() != 0) begin
                    ev = ev_q.pop_front();
                    check("ev_frame_done", 32'(ev), 32'(EV_DONE));
                end
                $display("event frame_done at t=%0t", $time);
            end
            if (underrun) begin
                check("underrun_expected", 32'(ev_q.size() != 0), 32'd1);
                if (ev_q.size() != 0) begin
                    ev = ev_q.pop_front();
                    check("ev_underrun", 32'(ev), 32'(EV_UNDERRUN));
                end
                $display("event underrun at t=%0t", $time);
            end
        end
    end

    initial begin : stimulus
        int n;
        reset_n = 1'b0;

        // 64-byte frame queued while reset is held; fifo_en must stay low.
        st_clear();
        for (int i = 0; i < 64; i++) st_add(8'(i * 37 + 5), 1'b0);
        load_frame(-1, 1'b0, 32'h0, "64byte");
        repeat (3) @(negedge clock);
        check("rst_tx_en", {31'h0, tx_en}, 32'd0);
        check("rst_txd", {24'h0, txd}, 32'd0);
        check("rst_tx_er", {31'h0, tx_er}, 32'd0);
        check("rst_frame_done", {31'h0, frame_done}, 32'd0);
        check("rst_underrun", {31'h0, underrun}, 32'd0);
        check("rst_fifo_en", {31'h0, fifo_en}, 32'd0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        wait_idle("f64");

        // CRC check vector: FCS bytes 26 39 F4 CB when the FCS is enabled.
        st_clear();
        for (int i = 0; i < 9; i++) st_add(8'(8'h31 + i), 1'b0);
        load_frame(-2, 1'b1, 32'hCBF43926, "123456789");
        wait_idle("crc");

        // Error flag on payload index 3 is forwarded, frame still completes.
        st_clear();
        for (int i = 0; i < 8; i++) st_add(8'(8'hA0 + i), (i == 3));
        load_frame(-2, 1'b0, 32'h0, "er_at_3");
        wait_idle("er");

        // Back-to-back frames; the second is a single-byte frame.
        st_clear();
        for (int i = 0; i < 5; i++) st_add(8'(8'h10 + i), 1'b0);
        load_frame(-2, 1'b0, 32'h0, "b2b_a");
        st_clear();
        st_add(8'hEE, 1'b0);
        load_frame(12, 1'b0, 32'h0, "b2b_b");
        wait_idle("b2b");

        // Underrun after 10 of 20 bytes; remainder arrives 5 cycles later and is dropped.
        push_preamble(-2);
        for (int i = 0; i < 10; i++) begin
            fq.push_back({1'b0, 1'b0, 8'(8'h60 + i)});
            push_exp(8'(8'h60 + i), 1'b0, -1);
        end
        push_exp(8'h00, 1'b1, -1);
        ev_q.push_back(EV_UNDERRUN);
        $display("frame underrun: 10 of 20 bytes queued");
        n = 0;
        while (fq.size() != 0 && n < 200) begin @(negedge clock); n++; end
        check("underrun_drain_timeout", 32'(n < 200), 32'd1);
        repeat (5) @(negedge clock);
        for (int i = 10; i < 20; i++) fq.push_back({(i == 19), 1'b0, 8'(8'h60 + i)});
        st_clear();
        for (int i = 0; i < 3; i++) st_add(8'(8'hC0 + i), 1'b0);
        load_frame(-2, 1'b0, 32'h0, "after_underrun");
        wait_idle("underrun");

        // Reset pulsed while payload byte 5 is on the wire.
        push_preamble(-2);
        for (int i = 0; i < 20; i++) fq.push_back({(i == 19), 1'b0, 8'(8'h80 + i)});
        for (int i = 0; i < 4; i++) push_exp(8'(8'h80 + i), 1'b0, -1);
        $display("frame reset_mid: 20 bytes queued, reset at payload byte 5");
        n = 0;
        while (!tx_en && n < 200) begin @(negedge clock); n++; end
        check("reset_start_timeout", 32'(n < 200), 32'd1);
        repeat (12) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_tx_en", {31'h0, tx_en}, 32'd0);
        check("midrst_txd", {24'h0, txd}, 32'd0);
        check("midrst_tx_er", {31'h0, tx_er}, 32'd0);
        check("midrst_fifo_en", {31'h0, fifo_en}, 32'd0);
        fq.delete();
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_idle", {31'h0, tx_en}, 32'd0);
        st_clear();
        for (int i = 0; i < 4; i++) st_add(8'(8'hF0 + i), 1'b0);
        load_frame(-1, 1'b0, 32'h0, "after_reset");
        wait_idle("reset");

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("ev_q_empty", 32'(ev_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got %0d compared, expected completion", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gmii_frame_tx.md
GMII_FRAME_TX -- requirements
Module: gmii_frame_tx

Interface
REQ-001 SHALL: clock  input  1  GMII transmit clock (gtx_clk domain, 125 MHz); every register in the block is clocked on its rising edge.
REQ-002 SHALL: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: fifo_empty  input  1  packet FIFO empty flag; the FIFO is show-ahead, so fifo_d/fifo_er/fifo_frame_end are valid whenever fifo_empty=0.
REQ-004 SHALL: fifo_d  input  8  payload byte at the FIFO head.
REQ-005 SHALL: fifo_er  input  1  receive-error flag carried with the byte.
REQ-006 SHALL: fifo_frame_end  input  1  marks the last byte of a frame.
REQ-007 SHALL: fifo_en  output  1  read acknowledge; pops the head word in the same cycle; combinational from state and fifo_empty.
REQ-008 SHALL: tx_en  output  1  GMII TX_EN, registered.
REQ-009 SHALL: txd  output  8  GMII TXD, registered.
REQ-010 SHALL: tx_er  output  1  GMII TX_ER, registered.
REQ-011 SHALL: frame_done  output  1  one-cycle pulse when a frame completes without underrun.
REQ-012 SHALL: underrun  output  1  one-cycle pulse when the FIFO empties mid-frame.

Function
REQ-013 SHALL: the state machine has states IDLE, PREAMBLE, SFD, DATA, FCS, DROP and IFG.
REQ-014 SHALL: IDLE -> PREAMBLE when fifo_empty=0; otherwise stay in IDLE with tx_en=0, txd=0x00, tx_er=0.
REQ-015 SHALL: PREAMBLE drives 7 consecutive cycles of tx_en=1, txd=0x55, then moves to SFD.
REQ-016 SHALL: SFD drives one cycle of txd=0xD5; fifo_en is asserted in this cycle.
REQ-017 SHALL: in SFD and DATA, fifo_en = !fifo_empty.
REQ-018 SHALL: a word popped in cycle t drives txd=fifo_d, tx_er=fifo_er and tx_en=1 in cycle t+1.
REQ-019 SHALL: popping a word with fifo_frame_end=1 causes the next state to be FCS (macro defined) or IFG (macro undefined).
REQ-020 SHALL: latency is fixed: first payload byte appears on txd 8 cycles after the first tx_en=1 cycle; the gap between consecutive payload bytes is 0 cycles.
REQ-021 SHALL: if fifo_empty=1 while a pop is required in SFD or DATA, the block pulses underrun, drives tx_en=1, tx_er=1, txd=0x00 for one cycle, then enters DROP.
REQ-022 SHALL: in DROP, fifo_en = !fifo_empty and tx_en=0; words are discarded until a word with fifo_frame_end=1 is popped, then the state moves to IFG.
REQ-023 SHALL: IFG holds tx_en=0 for exactly 12 cycles, then returns to IDLE; a FIFO that is non-empty during IFG is not read.
REQ-024 SHALL: frame_done pulses in the first IFG cycle, only when the frame did not pass through DROP.
REQ-025 SHALL: a received fifo_er=1 byte is forwarded as tx_er=1 and does not abort the frame.
REQ-026 SHALL: no padding is applied; frames are sent at whatever length the FIFO supplies.

Reset
REQ-027 SHALL: reset_n=0 asynchronously forces state=IDLE, tx_en=0, txd=0x00, tx_er=0, frame_done=0, underrun=0, the IFG counter to 0 and the CRC register to 0xFFFFFFFF.
REQ-028 SHALL: reset asserted mid-frame truncates the frame with no tx_er; the FIFO is not drained by this block.
REQ-029 SHALL: fifo_en=0 whenever reset_n=0.

Configuration
REQ-030 SHALL: with GMII_TX_FCS_EN defined, the block computes the Ethernet CRC-32 over all payload bytes (reflected polynomial 0x04C11DB7, initial value 0xFFFFFFFF, final complement) and the FCS state appends 4 bytes, least-significant byte first.
REQ-031 SHALL: with GMII_TX_FCS_EN defined, the CRC register is reinitialised in PREAMBLE.
REQ-032 SHALL: with GMII_TX_FCS_EN undefined, the FCS state and CRC logic are absent and the payload is assumed to already contain the FCS.

Verification
REQ-033 SHALL: a 64-byte frame in the FIFO with the macro undefined -> 0x55 x7, 0xD5, then 64 bytes back-to-back, tx_en low for 12 cycles, one frame_done pulse.
REQ-034 SHALL: payload ASCII "123456789" with GMII_TX_FCS_EN defined -> trailing bytes 0x26, 0x39, 0xF4, 0xCB, then IFG.
REQ-035 SHALL: FIFO empties after byte 10 of 20, remainder including frame_end arrives 5 cycles later -> one cycle tx_er=1, one underrun pulse, remainder discarded, no frame_done, 12-cycle IFG.
REQ-036 SHALL: two frames queued back-to-back -> exactly 12 idle cycles between the last byte (or FCS) of frame 1 and the first preamble byte of frame 2.
REQ-037 SHALL: reset_n pulsed low during byte 5 of DATA -> outputs go to 0 immediately and the block returns to IDLE; the next non-empty FIFO starts a fresh preamble.
REQ-038 SHALL: a byte with fifo_er=1 at payload index 3 -> tx_er=1 on exactly that txd cycle and the frame completes normally.
